// File: rtl/scm_fifo_pkg.sv
// Shared constants and helpers for the SCM-backed FIFO controller.
package scm_fifo_pkg;

    localparam int OB_DEPTH = 2;

    // Occupancy spans storage depth plus the in-flight read plus the output buffer.
    function automatic int cnt_width(input int addr_width);
        return addr_width + 2;
    endfunction

endpackage

// File: rtl/scm_fifo_outbuf.sv
// Two-entry in-order output buffer fed by the storage read port.
module scm_fifo_outbuf
    import scm_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_flush,
    input  logic                  i_capture,
    input  logic                  i_pop,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [1:0]            o_cnt
);

    logic [DATA_WIDTH-1:0] r_data [OB_DEPTH];
    logic                  r_head;
    logic [1:0]            r_cnt;
    logic                  w_pop;
    logic                  w_tail;

    assign w_pop  = i_pop & (r_cnt != 2'd0);
    assign w_tail = r_head ^ r_cnt[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < OB_DEPTH; i++) r_data[i] <= '0;
            r_head <= 1'b0;
            r_cnt  <= 2'd0;
        end else if (i_flush) begin
            r_head <= 1'b0;
            r_cnt  <= 2'd0;
        end else begin
            if (i_capture) r_data[w_tail] <= i_data;
            if (w_pop)     r_head         <= ~r_head;
            r_cnt <= r_cnt + {1'b0, i_capture} - {1'b0, w_pop};
        end
    end

    assign o_valid = (r_cnt != 2'd0);
    assign o_data  = r_data[r_head];
    assign o_cnt   = r_cnt;

endmodule

// File: rtl/scm_fifo_ctrl.sv
// Streaming FIFO controller over a 1R/1W register file with a registered read port.
module scm_fifo_ctrl
    import scm_fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush_i,
    input  logic                          push_valid_i,
    output logic                          push_ready_o,
    input  logic [DATA_WIDTH-1:0]         push_data_i,
    output logic                          pop_valid_o,
    input  logic                          pop_ready_i,
    output logic [DATA_WIDTH-1:0]         pop_data_o,
    output logic [ADDR_WIDTH+1:0]         count_o,
    output logic                          mem_write_enable_o,
    output logic [ADDR_WIDTH-1:0]         mem_write_addr_o,
    output logic [DATA_WIDTH-1:0]         mem_write_data_o,
    output logic [DATA_WIDTH/8-1:0]       mem_write_be_o,
    output logic                          mem_read_enable_o,
    output logic [ADDR_WIDTH-1:0]         mem_read_addr_o,
    input  logic [DATA_WIDTH-1:0]         mem_read_data_i
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int CW    = cnt_width(ADDR_WIDTH);

    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_mem_cnt;
    logic                  r_rd_pend;
    logic [1:0]            w_ob_cnt;
    logic [2:0]            w_occ;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_issue;

    assign push_ready_o = (r_mem_cnt < (ADDR_WIDTH+1)'(DEPTH)) & ~flush_i;
    assign w_push       = push_valid_i & push_ready_o;
    assign w_pop        = pop_valid_o & pop_ready_i & ~flush_i;

    // A slot being popped this cycle is free again at the edge, so the next
    // read may be issued into it; this keeps one word per cycle in steady state.
    assign w_occ   = {1'b0, w_ob_cnt} + {2'b00, r_rd_pend} - {2'b00, w_pop};
    assign w_issue = (r_mem_cnt != '0) & (w_occ < 3'(OB_DEPTH)) & ~flush_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_mem_cnt <= '0;
            r_rd_pend <= 1'b0;
        end else if (flush_i) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_mem_cnt <= '0;
            r_rd_pend <= 1'b0;
        end else begin
            if (w_push)  r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_issue) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_mem_cnt <= r_mem_cnt + {{ADDR_WIDTH{1'b0}}, w_push}
                                   - {{ADDR_WIDTH{1'b0}}, w_issue};
            r_rd_pend <= w_issue;
        end
    end

    scm_fifo_outbuf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_outbuf (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_flush   (flush_i),
        .i_capture (r_rd_pend),
        .i_pop     (w_pop),
        .i_data    (mem_read_data_i),
        .o_valid   (pop_valid_o),
        .o_data    (pop_data_o),
        .o_cnt     (w_ob_cnt)
    );

    assign count_o = CW'(r_mem_cnt) + CW'(r_rd_pend) + CW'(w_ob_cnt);

    assign mem_write_enable_o = w_push;
    assign mem_write_addr_o   = r_wr_ptr;
    assign mem_write_data_o   = push_data_i;
    assign mem_write_be_o     = '1;
    assign mem_read_enable_o  = w_issue;
    assign mem_read_addr_o    = r_rd_ptr;

endmodule

// File: tb/tb_scm_fifo_ctrl.sv
// Self-checking bench for scm_fifo_ctrl with a behavioural 1R/1W storage model.
module tb_scm_fifo_ctrl;

    localparam int AW    = 5;
    localparam int DW    = 64;
    localparam int DEPTH = 2 ** AW;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic          push_valid;
    logic          push_ready;
    logic [DW-1:0] push_data;
    logic          pop_valid;
    logic          pop_ready;
    logic [DW-1:0] pop_data;
    logic [AW+1:0] count;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;
    logic [DW/8-1:0] mem_be;
    logic          mem_re;
    logic [AW-1:0] mem_raddr;
    logic [DW-1:0] mem_rdata;

    int n_checks = 0;
    int n_errors = 0;

    scm_fifo_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .flush_i            (flush),
        .push_valid_i       (push_valid),
        .push_ready_o       (push_ready),
        .push_data_i        (push_data),
        .pop_valid_o        (pop_valid),
        .pop_ready_i        (pop_ready),
        .pop_data_o         (pop_data),
        .count_o            (count),
        .mem_write_enable_o (mem_we),
        .mem_write_addr_o   (mem_waddr),
        .mem_write_data_o   (mem_wdata),
        .mem_write_be_o     (mem_be),
        .mem_read_enable_o  (mem_re),
        .mem_read_addr_o    (mem_raddr),
        .mem_read_data_i    (mem_rdata)
    );

    // Storage model: registered read returns the old word on a same-edge write.
    logic [DW-1:0] storage [DEPTH];
    initial mem_rdata = '0;
    always @(posedge clk) begin
        if (mem_we) storage[mem_waddr] <= mem_wdata;
        if (mem_re) mem_rdata <= storage[mem_raddr];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) chk("write_be", 64'(mem_be), 64'hFF);

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        pv;
        logic [63:0] pd;
        logic        pr;
        logic        fl;
        logic        e_prdy;
        logic        e_pvld;
        logic [63:0] e_pdata;
        logic [6:0]  e_cnt;
        logic        e_we;
        logic        e_re;
    } vec_t;

    vec_t vecs [12];

    initial begin
        int          acc;
        int          idx;
        int          sent;
        int          got;
        int          first;
        int          gaps;
        int          cyc;
        logic [63:0] q [$];

        //            pv  pd      pr  fl  prdy pvld pdata   cnt we  re
        vecs[0]  = '{1'b1, 64'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 64'h0,  7'd0, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 64'h0,  1'b1, 1'b0, 1'b1, 1'b0, 64'h0,  7'd1, 1'b0, 1'b1};
        vecs[2]  = '{1'b0, 64'h0,  1'b1, 1'b0, 1'b1, 1'b0, 64'h0,  7'd1, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 64'h0,  1'b1, 1'b0, 1'b1, 1'b1, 64'hA5, 7'd1, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 64'h0,  1'b1, 1'b0, 1'b1, 1'b0, 64'h0,  7'd0, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 64'h10, 1'b1, 1'b0, 1'b1, 1'b0, 64'h0,  7'd0, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 64'h11, 1'b1, 1'b0, 1'b1, 1'b0, 64'h0,  7'd1, 1'b1, 1'b1};
        vecs[7]  = '{1'b1, 64'h12, 1'b1, 1'b0, 1'b1, 1'b0, 64'h0,  7'd2, 1'b1, 1'b1};
        vecs[8]  = '{1'b0, 64'h0,  1'b1, 1'b0, 1'b1, 1'b1, 64'h10, 7'd3, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 64'h0,  1'b1, 1'b0, 1'b1, 1'b1, 64'h11, 7'd2, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 64'h0,  1'b1, 1'b0, 1'b1, 1'b1, 64'h12, 7'd1, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 64'h77, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0,  7'd0, 1'b0, 1'b0};

        rst_n = 1'b0; flush = 1'b0; push_valid = 1'b0; push_data = '0; pop_ready = 1'b0;
        #12;
        chk("rst_push_ready", 64'(push_ready), 1);
        chk("rst_pop_valid",  64'(pop_valid), 0);
        chk("rst_pop_data",   pop_data, 0);
        chk("rst_count",      64'(count), 0);
        chk("rst_we",         64'(mem_we), 0);
        chk("rst_re",         64'(mem_re), 0);
        chk("rst_raddr",      64'(mem_raddr), 0);
        chk("rst_waddr",      64'(mem_waddr), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table: single-word latency, back-to-back burst, flush with push
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            push_valid = vecs[i].pv; push_data = vecs[i].pd;
            pop_ready  = vecs[i].pr; flush     = vecs[i].fl;
            #1;
            chk($sformatf("vec%0d_push_ready", i), 64'(push_ready), 64'(vecs[i].e_prdy));
            chk($sformatf("vec%0d_pop_valid", i),  64'(pop_valid),  64'(vecs[i].e_pvld));
            chk($sformatf("vec%0d_count", i),      64'(count),      64'(vecs[i].e_cnt));
            chk($sformatf("vec%0d_we", i),         64'(mem_we),     64'(vecs[i].e_we));
            chk($sformatf("vec%0d_re", i),         64'(mem_re),     64'(vecs[i].e_re));
            if (vecs[i].e_pvld) chk($sformatf("vec%0d_pop_data", i), pop_data, vecs[i].e_pdata);
        end
        @(negedge clk);
        flush = 1'b0; push_valid = 1'b0; pop_ready = 1'b0;
        #1;
        chk("post_flush_count", 64'(count), 0);

        // Fill with consumer stalled: capacity is DEPTH + 2
        acc = 0;
        for (int c = 0; c < 45; c++) begin
            @(negedge clk);
            push_valid = 1'b1; push_data = 64'(acc); pop_ready = 1'b0;
            #1;
            if (push_ready) acc++;
        end
        chk("fill_accepted", 64'(acc), DEPTH + 2);
        chk("fill_push_ready", 64'(push_ready), 0);
        chk("fill_count", 64'(count), DEPTH + 2);
        idx = 0;
        for (int c = 0; c < 100 && idx < DEPTH + 2; c++) begin
            @(negedge clk);
            push_valid = 1'b0; pop_ready = 1'b1;
            #1;
            if (pop_valid) begin
                chk("drain_data", pop_data, 64'(idx));
                idx++;
            end
        end
        chk("drain_words", 64'(idx), DEPTH + 2);
        @(negedge clk);
        pop_ready = 1'b0;
        #1;
        chk("drain_count", 64'(count), 0);

        // Continuous streaming across pointer wrap
        sent = 0; got = 0; first = -1; gaps = 0; cyc = 0;
        for (int c = 0; c < 300 && got < 100; c++) begin
            @(negedge clk);
            push_valid = (sent < 100); push_data = 64'(1000 + sent); pop_ready = 1'b1;
            #1;
            if (push_valid && push_ready) sent++;
            if (pop_valid) begin
                chk("stream_data", pop_data, 64'(1000 + got));
                if (first < 0) first = cyc;
                got++;
            end else if (first >= 0) begin
                gaps++;
            end
            cyc++;
        end
        push_valid = 1'b0;
        chk("stream_words", 64'(got), 100);
        chk("stream_latency", 64'(first), 3);
        chk("stream_gaps", 64'(gaps), 0);

        // Random traffic against a scoreboard
        q.delete();
        for (int c = 0; c < 400; c++) begin
            logic do_push;
            logic do_pop;
            @(negedge clk);
            push_valid = 1'($urandom_range(0, 1));
            pop_ready  = 1'($urandom_range(0, 1));
            push_data  = {$urandom, $urandom};
            #1;
            chk("rand_count", 64'(count), 64'(q.size()));
            do_push = push_valid & push_ready;
            do_pop  = pop_valid & pop_ready;
            if (do_pop) begin
                if (q.size() > 0) begin
                    chk("rand_data", pop_data, q[0]);
                    void'(q.pop_front());
                end else begin
                    chk("rand_pop_when_empty", 64'(pop_valid), 0);
                end
            end
            if (do_push) q.push_back(push_data);
        end
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            push_valid = 1'b0; pop_ready = 1'b1;
        end
        #1;
        chk("rand_drained", 64'(count), 0);

        // Flush with 10 words in storage and one read in flight
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            push_valid = 1'b1; push_data = 64'(12'h300 + i); pop_ready = 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            push_valid = 1'b0;
        end
        #1;
        chk("flush_pre_count", 64'(count), 13);
        @(negedge clk);
        pop_ready = 1'b1;
        #1;
        chk("flush_pop_head", pop_data, 64'h300);
        chk("flush_pop_issue", 64'(mem_re), 1);
        @(negedge clk);
        pop_ready = 1'b0; flush = 1'b1; push_valid = 1'b1; push_data = 64'hDEAD;
        #1;
        chk("flush_count_before", 64'(count), 12);
        chk("flush_push_ready", 64'(push_ready), 0);
        @(negedge clk);
        flush = 1'b0; push_valid = 1'b0;
        #1;
        chk("flush_count_after", 64'(count), 0);
        chk("flush_pop_valid", 64'(pop_valid), 0);
        @(negedge clk);
        push_valid = 1'b1; push_data = 64'h1;
        @(negedge clk);
        push_valid = 1'b0; pop_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 10 && !pop_valid; c++) begin
            @(negedge clk);
            idx++;
        end
        #1;
        chk("flush_repush_valid", 64'(pop_valid), 1);
        chk("flush_repush_data", pop_data, 64'h1);
        chk("flush_repush_count", 64'(count), 1);
        @(negedge clk);
        pop_ready = 1'b1;
        @(negedge clk);
        pop_ready = 1'b0;
        #1;
        chk("flush_repush_empty", 64'(count), 0);

        // Asynchronous reset in the middle of a stream
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            push_valid = 1'b1; push_data = 64'(12'h500 + i); pop_ready = (i > 3);
        end
        @(negedge clk);
        push_valid = 1'b0; pop_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_push_ready", 64'(push_ready), 1);
        chk("arst_pop_valid",  64'(pop_valid), 0);
        chk("arst_pop_data",   pop_data, 0);
        chk("arst_count",      64'(count), 0);
        chk("arst_we",         64'(mem_we), 0);
        chk("arst_re",         64'(mem_re), 0);
        chk("arst_raddr",      64'(mem_raddr), 0);
        chk("arst_waddr",      64'(mem_waddr), 0);
        chk("arst_be",         64'(mem_be), 64'hFF);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("arst_release_count", 64'(count), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
